mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 104 ++++++++++
 tb/tb_mult_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Sequential radix-8 Booth multiplier. Each enabled RUN cycle retires one
// 3-bit multiplier digit, so NDIG cycles produce a 2*WIDTH-bit product.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               En,
  input  logic               Start,
  input  logic               Sign,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [3:0]         Num,
  output logic [2*WIDTH-1:0] Product
);
  // state | meaning
  // IDLE  | waiting for Start
  // RUN   | accumulating one Booth digit per enabled cycle
  // DONE  | Product valid, Done pulse
  localparam int NDIG = (WIDTH + 3) / 3;
  localparam int BW   = 3 * NDIG;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [PW-1:0] a_sh;
  logic [PW-1:0] a_x3;
  logic [PW-1:0] acc;
  logic [PW-1:0] pp;
  logic [BW:0]   b_sh;  // bit 0 carries b[3i-1] of the current window
  logic [CW-1:0] cnt;
  logic [3:0]    win;
  logic          last;

  assign win  = b_sh[3:0];
  assign last = (cnt == '0);
  assign a_x3 = a_sh + (a_sh << 1);

  always_comb begin
    pp = '0;
    case (win)
      4'b0001, 4'b0010: pp = a_sh;
      4'b0011, 4'b0100: pp = a_sh << 1;
      4'b0101, 4'b0110: pp = a_x3;
      4'b0111:          pp = a_sh << 2;
      4'b1000:          pp = -(a_sh << 2);
      4'b1001, 4'b1010: pp = -a_x3;
      4'b1011, 4'b1100: pp = -(a_sh << 1);
      4'b1101, 4'b1110: pp = -a_sh;
      default:          pp = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (En) begin
      case (state)
        IDLE:    if (Start) state_next = RUN;
        RUN:     if (last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // A shifts up and B shifts down by one digit per step, so the window and
  // the partial-product weight never need a variable shifter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      Product <= '0;
    end else if (En) begin
      if (state == IDLE && Start) begin
        a_sh <= Sign ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_sh <= {{(BW-WIDTH){Sign & B[WIDTH-1]}}, B, 1'b0};
        acc  <= '0;
        cnt  <= CW'(NDIG - 1);
      end else if (state == RUN) begin
        acc  <= acc + pp;
        a_sh <= a_sh << 3;
        b_sh <= b_sh >> 3;
        if (last) Product <= acc + pp;
        else      cnt <= cnt - 1'b1;
      end
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);
  assign Num  = Busy ? win : 4'b0000;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed and randomized checks of mult_sequencer against a plain
// arithmetic product model.
module tb_mult_sequencer;
  localparam int W    = 32;
  localparam int NDIG = (W + 3) / 3;

  logic          Clk = 1'b0;
  logic          Reset, En, Start, Sign;
  logic [W-1:0]  A, B;
  logic          Busy, Done;
  logic [3:0]    Num;
  logic [2*W-1:0] Product;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] last_prod;

  mult_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Start(Start), .Sign(Sign),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Num(Num), .Product(Product)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [2*W-1:0] exp;
    logic [3*NDIG:0] bx;
    int lat;
    exp = model(s, a, b);
    bx  = {{(3*NDIG-W){s & b[W-1]}}, b, 1'b0};
    Sign = s; A = a; B = b; Start = 1'b1;
    step();
    Start = 1'b0; A = $urandom; B = $urandom; Sign = ~s;
    lat = 0;
    while (Done !== 1'b1 && lat < 40) begin
      chk({tag, "_busy"}, Busy, 1);
      if (lat < NDIG) chk({tag, "_num"}, Num, bx[3*lat +: 4]);
      if (lat == 5) chk({tag, "_hold_prev"}, Product, last_prod);
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, NDIG);
    chk({tag, "_product"}, Product, exp);
    step();
    chk({tag, "_done_clr"}, Done, 0);
    chk({tag, "_busy_clr"}, Busy, 0);
    chk({tag, "_num_idle"}, Num, 0);
    chk({tag, "_prod_held"}, Product, exp);
    last_prod = exp;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0] num_frz;
    logic [2*W-1:0] exp;
    logic rs, prev_busy;
    int dones, per, k;

    Reset = 1'b1; En = 1'b0; Start = 1'b1; Sign = 1'b0; A = '0; B = '0;
    step();
    step();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_num", Num, 0);
    chk("rst_prod", Product, 0);
    Reset = 1'b0; En = 1'b1; Start = 1'b0;
    last_prod = '0;
    step();

    run_op(1'b0, 32'd3, 32'd5, "u3x5");
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "u_max");
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, "s_m1m1");
    run_op(1'b1, 32'h80000000, 32'h80000000, "s_minmin");
    run_op(1'b1, 32'hFFFFFFFF, 32'd1, "s_m1x1");

    // Start held high: one accept, one Done, next accept 13 edges later
    Sign = 1'b0; A = 32'd2; B = 32'd7; Start = 1'b1;
    step();
    chk("hold_busy", Busy, 1);
    dones = 0; per = 0; prev_busy = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (Done === 1'b1) begin
        dones++;
        chk("hold_prod", Product, 14);
      end
      if (Busy === 1'b1 && prev_busy === 1'b0) begin
        per = j;
        break;
      end
      prev_busy = Busy;
    end
    Start = 1'b0;
    chk("hold_dones", dones, 1);
    chk("hold_period", per, 13);
    k = 0;
    while (Done !== 1'b1 && k < 40) begin step(); k++; end
    chk("hold_prod2", Product, 14);
    step();
    last_prod = 64'd14;

    // En low for 4 cycles mid-RUN, then low again while Done is pending
    ra = $urandom; rb = $urandom;
    exp = model(1'b1, ra, rb);
    Sign = 1'b1; A = ra; B = rb; Start = 1'b1;
    step();
    Start = 1'b0;
    k = 0; num_frz = '0;
    while (Done !== 1'b1 && k < 60) begin
      if (k == 3) begin En = 1'b0; num_frz = Num; end
      if (k == 7) begin
        chk("stall_busy", Busy, 1);
        chk("stall_num", Num, num_frz);
        En = 1'b1;
      end
      step();
      k++;
    end
    chk("stall_latency", k, NDIG + 4);
    chk("stall_prod", Product, exp);
    En = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("stall_done_hold", Done, 1);
    end
    En = 1'b1;
    step();
    chk("stall_done_clr", Done, 0);
    chk("stall_prod_held", Product, exp);

    // Reset mid-RUN, also overriding a simultaneous Start
    Sign = 1'b0; A = 32'd9; B = 32'd11; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int j = 0; j < 4; j++) step();
    chk("abort_running", Busy, 1);
    Reset = 1'b1; Start = 1'b1;
    step();
    Reset = 1'b0; Start = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_num", Num, 0);
    chk("abort_prod", Product, 0);
    dones = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      if (Done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    last_prod = '0;
    run_op(1'b0, 32'd6, 32'd7, "after_rst");

    for (int j = 0; j < 20; j++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'h80000000;
        1:       rb = 32'd0;
        default: rb = $urandom;
      endcase
      run_op(rs, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
